// File: rtl/mips_mem_pkg.sv
// Shared types for the data-memory arbiter: FSM states and requester port IDs.
package mips_mem_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; the last-grant history is held by the caller.
module rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic       o_gnt_valid,
   output logic       o_gnt
);
   // On a tie the port that did not win last time goes next.
   always_comb begin
      o_gnt_valid = |i_req;
      o_gnt       = (&i_req) ? ~i_last_grant : i_req[1];
   end
endmodule

// File: rtl/d_mem_arbiter.sv
// Shares d_mem between the CPU load/store port and the debug/DMA port,
// one granted request at a time, each as one registered memory cycle.
module d_mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int SIZE = 1024,
   parameter int AW   = 32,
   parameter int DW   = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          Req0,
   input  logic          Wr0,
   input  logic [AW-1:0] Addr0,
   input  logic [DW-1:0] WData0,
   output logic          Ack0,
   output logic          Err0,
   output logic [DW-1:0] RData0,
   input  logic          Req1,
   input  logic          Wr1,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WData1,
   output logic          Ack1,
   output logic          Err1,
   output logic [DW-1:0] RData1,
   output logic [AW-1:0] MemAddress,
   output logic [DW-1:0] MemWData,
   output logic          MemWrite,
   output logic          MemRead,
   input  logic [DW-1:0] MemRData
);
   state_t        r_state;
   logic          r_last;
   logic          r_gnt;
   logic          r_wr;
   logic          r_fault;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_mem_write;
   logic          r_mem_read;
   logic          r_ack0, r_ack1;
   logic          r_err0, r_err1;
   logic [DW-1:0] r_rdata0, r_rdata1;

   logic          w_gnt_valid;
   logic          w_gnt;
   logic          w_wr;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic          w_fault;
   logic [DW-1:0] w_rdata;

   rr_arb2 u_arb (
      .i_req        ({Req1, Req0}),
      .i_last_grant (r_last),
      .o_gnt_valid  (w_gnt_valid),
      .o_gnt        (w_gnt)
   );

   always_comb begin
      w_wr    = (w_gnt == PORT_DBG) ? Wr1    : Wr0;
      w_addr  = (w_gnt == PORT_DBG) ? Addr1  : Addr0;
      w_wdata = (w_gnt == PORT_DBG) ? WData1 : WData0;
      // Misaligned or beyond the last word; addresses never wrap.
      w_fault = (w_addr[1:0] != 2'b00) || (w_addr[AW-1:2] >= (AW-2)'(SIZE));
      w_rdata = (!r_wr && !r_fault) ? MemRData : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_last      <= PORT_DBG;
         r_gnt       <= PORT_CPU;
         r_wr        <= 1'b0;
         r_fault     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_ack0      <= 1'b0;
         r_ack1      <= 1'b0;
         r_err0      <= 1'b0;
         r_err1      <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_gnt_valid) begin
                  r_gnt       <= w_gnt;
                  r_wr        <= w_wr;
                  r_fault     <= w_fault;
                  r_addr      <= w_addr;
                  r_wdata     <= w_wdata;
                  r_mem_write <= w_wr && !w_fault;
                  r_mem_read  <= !w_wr && !w_fault;
                  r_state     <= ACCESS;
               end
            end
            ACCESS: begin
               r_mem_write <= 1'b0;
               r_mem_read  <= 1'b0;
               if (r_gnt == PORT_DBG) begin
                  r_ack1   <= 1'b1;
                  r_err1   <= r_fault;
                  r_rdata1 <= w_rdata;
               end else begin
                  r_ack0   <= 1'b1;
                  r_err0   <= r_fault;
                  r_rdata0 <= w_rdata;
               end
               r_state <= RESP;
            end
            RESP: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_err0  <= 1'b0;
               r_err1  <= 1'b0;
               r_last  <= r_gnt;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign MemAddress = r_addr;
   assign MemWData   = r_wdata;
   assign MemWrite   = r_mem_write;
   assign MemRead    = r_mem_read;
   assign Ack0       = r_ack0;
   assign Ack1       = r_ack1;
   assign Err0       = r_err0;
   assign Err1       = r_err1;
   assign RData0     = r_rdata0;
   assign RData1     = r_rdata1;
endmodule
